// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I/D caches, the refill/writeback arbiter and memory.
// slave: arbiter side; master: cache/memory environment side.
interface cache_mem_arbiter_if #(
  parameter int unsigned LINE_WIDTH = 512
);
  // icache refill
  logic                  i_rd_req;
  logic [31:0]           i_rd_addr;
  logic                  i_rd_rdy;
  logic                  i_ret_valid;
  logic                  i_ret_last;
  logic [31:0]           i_ret_data;
  // dcache refill
  logic                  d_rd_req;
  logic [31:0]           d_rd_addr;
  logic                  d_rd_rdy;
  logic                  d_ret_valid;
  logic                  d_ret_last;
  logic [31:0]           d_ret_data;
  // dcache writeback
  logic                  d_wr_req;
  logic [31:0]           d_wr_addr;
  logic [LINE_WIDTH-1:0] d_wr_data;
  logic                  d_wr_rdy;
  // memory refill
  logic                  m_rd_req;
  logic [31:0]           m_rd_addr;
  logic                  m_rd_rdy;
  logic                  m_ret_valid;
  logic                  m_ret_last;
  logic [31:0]           m_ret_data;
  // memory writeback
  logic                  m_wr_req;
  logic [31:0]           m_wr_addr;
  logic [LINE_WIDTH-1:0] m_wr_data;
  logic                  m_wr_rdy;

  modport slave (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_wr_req, d_wr_addr, d_wr_data,
           m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data, m_wr_rdy,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
           d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data, d_wr_rdy,
    output m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data
  );

  modport master (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_wr_req, d_wr_addr, d_wr_data,
           m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data, m_wr_rdy,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
           d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data, d_wr_rdy,
    input  m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one memory refill/writeback port between the icache and dcache.
// Refills are arbitrated round-robin (or dcache-first when
// CACHE_ARB_FIXED_PRIO_EN is defined); one dirty line is held in a
// single-entry write buffer, and refills hitting that line are held off.
module cache_mem_arbiter #(
  parameter int unsigned BYTES_PER_LINE = 64
) (
  input  logic               clk,
  input  logic               reset,
  cache_mem_arbiter_if.slave bus
);
  localparam int unsigned WORDS_PER_LINE = BYTES_PER_LINE / 4;
  localparam int unsigned LINE_WIDTH     = WORDS_PER_LINE * 32;
  localparam int unsigned OFFSET_WIDTH   = $clog2(BYTES_PER_LINE);
  localparam int unsigned BEAT_WIDTH     = $clog2(WORDS_PER_LINE);
  localparam logic [31:0] LINE_MASK      = ~32'(BYTES_PER_LINE - 1);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_BUSY} rd_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  rd_state_e             state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic [31:0]           rd_addr_q, rd_addr_d;
  logic [BEAT_WIDTH-1:0] beat_q, beat_d;
  logic                  wb_full_q, wb_full_d;
  logic [31:0]           wb_addr_q, wb_addr_d;
  logic [LINE_WIDTH-1:0] wb_data_q, wb_data_d;

  logic i_hazard, d_hazard, i_elig, d_elig, pick_d;
  logic grant_i, grant_d, wb_accept, wb_drain, busy;

  // Hazard detection and refill arbitration among eligible requesters
  always_comb begin
    i_hazard = wb_full_q && (bus.i_rd_addr[31:OFFSET_WIDTH] == wb_addr_q[31:OFFSET_WIDTH]);
    d_hazard = wb_full_q && (bus.d_rd_addr[31:OFFSET_WIDTH] == wb_addr_q[31:OFFSET_WIDTH]);
    i_elig   = bus.i_rd_req && !i_hazard;
    d_elig   = bus.d_rd_req && !d_hazard;
`ifdef CACHE_ARB_FIXED_PRIO_EN
    pick_d   = d_elig;
`else
    pick_d   = d_elig && (!i_elig || (last_grant_q == OWN_I));
`endif
    grant_d  = (state_q == R_IDLE) && pick_d;
    grant_i  = (state_q == R_IDLE) && i_elig && !pick_d;
  end

  // Read FSM next state: grant, wait for memory accept, stream beats
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rd_addr_d    = rd_addr_q;
    beat_d       = beat_q;
    case (state_q)
      R_IDLE: begin
        if (grant_i || grant_d) begin
          state_d      = R_REQ;
          owner_d      = grant_d ? OWN_D : OWN_I;
          last_grant_d = grant_d ? OWN_D : OWN_I;
          rd_addr_d    = (grant_d ? bus.d_rd_addr : bus.i_rd_addr) & LINE_MASK;
          beat_d       = '0;
        end
      end
      R_REQ: begin
        if (bus.m_rd_rdy) state_d = R_BUSY;
      end
      R_BUSY: begin
        if (bus.m_ret_valid) begin
          beat_d = bus.m_ret_last ? '0 : beat_q + BEAT_WIDTH'(1);
          if (bus.m_ret_last) begin
            state_d = R_IDLE;
            owner_d = OWN_NONE;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Single-entry write buffer: accept only when empty, drain when memory takes it
  always_comb begin
    wb_accept = bus.d_wr_req && !wb_full_q && !reset;
    wb_drain  = wb_full_q && bus.m_wr_rdy;
    wb_full_d = wb_full_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (wb_accept) begin
      wb_full_d = 1'b1;
      wb_addr_d = bus.d_wr_addr;
      wb_data_d = bus.d_wr_data;
    end else if (wb_drain) begin
      wb_full_d = 1'b0;
    end
  end

  // Output decode; return beats only reach the owner while a refill is streaming
  always_comb begin
    busy            = (state_q == R_BUSY);
    bus.i_rd_rdy    = grant_i && !reset;
    bus.d_rd_rdy    = grant_d && !reset;
    bus.d_wr_rdy    = !wb_full_q && !reset;
    bus.m_rd_req    = (state_q == R_REQ);
    bus.m_rd_addr   = rd_addr_q;
    bus.i_ret_valid = busy && (owner_q == OWN_I) && bus.m_ret_valid;
    bus.d_ret_valid = busy && (owner_q == OWN_D) && bus.m_ret_valid;
    bus.i_ret_last  = bus.i_ret_valid && bus.m_ret_last;
    bus.d_ret_last  = bus.d_ret_valid && bus.m_ret_last;
    bus.i_ret_data  = bus.m_ret_data;
    bus.d_ret_data  = bus.m_ret_data;
    bus.m_wr_req    = wb_full_q;
    bus.m_wr_addr   = wb_addr_q;
    bus.m_wr_data   = wb_data_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= R_IDLE;
      owner_q      <= OWN_NONE;
      last_grant_q <= OWN_I;
      rd_addr_q    <= '0;
      beat_q       <= '0;
      wb_full_q    <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rd_addr_q    <= rd_addr_d;
      beat_q       <= beat_d;
      wb_full_q    <= wb_full_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, corner-case sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_cache_mem_arbiter;
  localparam int unsigned LW = 512;
`ifdef CACHE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nerr = 0;
  int   nchk = 0;

  cache_mem_arbiter_if #(.LINE_WIDTH(LW)) bus ();
  cache_mem_arbiter #(.BYTES_PER_LINE(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_rd_req = 0; bus.i_rd_addr = '0; bus.d_rd_req = 0; bus.d_rd_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.m_rd_rdy = 0; bus.m_ret_valid = 0; bus.m_ret_last = 0; bus.m_ret_data = '0;
    bus.m_wr_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  function automatic logic [LW-1:0] pattern(input logic [31:0] seed);
    logic [LW-1:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = seed ^ (32'h0101_0101 * 32'(w));
    return v;
  endfunction

  typedef struct {
    logic        wr_first;
    logic [31:0] wr_addr;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        exp_i;
    logic        exp_d;
    logic [31:0] exp_maddr;
  } vec_t;
  vec_t vt[8];

  // reference-model state (abstract refill transaction + buffer contents)
  bit            mdl_full;
  logic [31:0]   mdl_wb_addr;
  logic [LW-1:0] mdl_wb_data;
  bit            mdl_pending;
  bit            mdl_stream;
  int            mdl_owner;
  int            mdl_last;
  logic [31:0]   mdl_addr;
  int            mem_cnt;

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0: base = 32'h0000_1000;
      1: base = 32'h0000_1040;
      2: base = 32'h0000_1080;
      default: base = 32'h0000_2000;
    endcase
    return base + 32'($urandom_range(0, 63));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[3];
    int ng;
    int cyc;
    bit streaming;
    int cnt;
    int exp_g[3];
    logic [31:0] prev_addr;

    idle_inputs();
    step();
    do_reset();

    // ---------------- directed grant table ----------------
    vt[0] = '{0, 0,            1, 32'h1fc0_0044, 0, 0,            1, 0, 32'h1fc0_0040};
    vt[1] = '{0, 0,            0, 0,             1, 32'h8000_107f, 0, 1, 32'h8000_1040};
    vt[2] = '{0, 0,            1, 32'h0000_3004, 1, 32'h0000_5008, 0, 1, 32'h0000_5000};
    vt[3] = '{1, 32'h8000_1000, 0, 0,            1, 32'h8000_1020, 0, 0, 0};
    vt[4] = '{1, 32'h8000_1000, 1, 32'h8000_2000, 1, 32'h8000_1020, 1, 0, 32'h8000_2000};
    vt[5] = '{1, 32'h8000_1000, 1, 32'h8000_103c, 0, 0,            0, 0, 0};
    vt[6] = '{1, 32'h8000_1000, 0, 0,            1, 32'h8000_1040, 0, 1, 32'h8000_1040};
    vt[7] = '{0, 0,            0, 0,             0, 0,            0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      #1;
      chk($sformatf("vec%0d reset_m_rd_req", k), bus.m_rd_req, 1'b0);
      if (vt[k].wr_first) begin
        bus.d_wr_req = 1; bus.d_wr_addr = vt[k].wr_addr; bus.d_wr_data = pattern(32'habcd_0000);
        step();
        bus.d_wr_req = 0;
      end
      bus.i_rd_req = vt[k].i_req; bus.i_rd_addr = vt[k].i_addr;
      bus.d_rd_req = vt[k].d_req; bus.d_rd_addr = vt[k].d_addr;
      #1;
      chk($sformatf("vec%0d i_rd_rdy", k), bus.i_rd_rdy, vt[k].exp_i);
      chk($sformatf("vec%0d d_rd_rdy", k), bus.d_rd_rdy, vt[k].exp_d);
      step();
      bus.i_rd_req = 0; bus.d_rd_req = 0;
      #1;
      chk($sformatf("vec%0d m_rd_req", k), bus.m_rd_req, vt[k].exp_i | vt[k].exp_d);
      if (vt[k].exp_i | vt[k].exp_d)
        chk($sformatf("vec%0d m_rd_addr", k), bus.m_rd_addr, vt[k].exp_maddr);
    end

    // ---------------- single icache refill, 16 beats ----------------
    do_reset();
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h1fc0_0044;
    #1;
    chk("refill grant", bus.i_rd_rdy, 1'b1);
    step();
    bus.i_rd_req = 0; bus.m_rd_rdy = 1;
    #1;
    chk("refill m_rd_req", bus.m_rd_req, 1'b1);
    chk("refill m_rd_addr", bus.m_rd_addr, 32'h1fc0_0040);
    step();
    bus.m_rd_rdy = 0;
    for (int b = 0; b < 16; b++) begin
      bus.m_ret_valid = 1; bus.m_ret_data = 32'(b); bus.m_ret_last = (b == 15);
      #1;
      chk($sformatf("beat%0d i_ret_valid", b), bus.i_ret_valid, 1'b1);
      chk($sformatf("beat%0d i_ret_last", b), bus.i_ret_last, (b == 15));
      chk($sformatf("beat%0d i_ret_data", b), bus.i_ret_data, 32'(b));
      chk($sformatf("beat%0d d_ret_valid", b), bus.d_ret_valid, 1'b0);
      step();
    end
    bus.m_ret_valid = 0; bus.m_ret_last = 0; bus.i_rd_req = 1; bus.i_rd_addr = 32'h0000_0100;
    #1;
    chk("refill done i_ret_valid", bus.i_ret_valid, 1'b0);
    chk("refill regrant", bus.i_rd_rdy, 1'b1);
    bus.i_rd_req = 0;

    // ---------------- grant order with both requesting ----------------
    do_reset();
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h0000_1000;
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_2000;
    bus.m_rd_rdy = 1;
    ng = 0; streaming = 0; cnt = 0; cyc = 0;
    while (ng < 3 && cyc < 300) begin
      bus.m_ret_valid = streaming; bus.m_ret_last = streaming && (cnt == 15); bus.m_ret_data = 32'(cnt);
      #1;
      if (bus.d_rd_rdy) begin g[ng] = 1; ng++; end
      else if (bus.i_rd_rdy) begin g[ng] = 0; ng++; end
      if (streaming) begin
        if (cnt == 15) begin streaming = 0; cnt = 0; end
        else cnt++;
      end else if (bus.m_rd_req && bus.m_rd_rdy) begin
        streaming = 1; cnt = 0;
      end
      step();
      cyc++;
    end
    chk("rr grant count", 32'(ng), 32'd3);
    exp_g[0] = 1; exp_g[1] = FIXED ? 1 : 0; exp_g[2] = 1;
    for (int k = 0; k < 3; k++)
      if (k < ng) chk($sformatf("grant order %0d", k), 32'(g[k]), 32'(exp_g[k]));
    idle_inputs();

    // ---------------- write-buffer hazard and second writeback ----------------
    do_reset();
    bus.d_wr_req = 1; bus.d_wr_addr = 32'h8000_1000; bus.d_wr_data = pattern(32'h1111_aaaa);
    #1;
    chk("wb first d_wr_rdy", bus.d_wr_rdy, 1'b1);
    step();
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h8000_1020;
    bus.d_wr_addr = 32'h8000_3000; bus.d_wr_data = pattern(32'h2222_5555);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hazard%0d d_rd_rdy", c), bus.d_rd_rdy, 1'b0);
      chk($sformatf("full%0d d_wr_rdy", c), bus.d_wr_rdy, 1'b0);
      chk($sformatf("full%0d m_wr_req", c), bus.m_wr_req, 1'b1);
      chk($sformatf("full%0d m_wr_addr", c), bus.m_wr_addr, 32'h8000_1000);
      chk($sformatf("full%0d m_wr_data", c), bus.m_wr_data, pattern(32'h1111_aaaa));
      step();
    end
    bus.m_wr_rdy = 1;
    #1;
    chk("drain cycle d_rd_rdy", bus.d_rd_rdy, 1'b0);
    chk("drain cycle d_wr_rdy", bus.d_wr_rdy, 1'b0);
    step();
    bus.m_wr_rdy = 0;
    #1;
    chk("after drain d_rd_rdy", bus.d_rd_rdy, 1'b1);
    chk("after drain d_wr_rdy", bus.d_wr_rdy, 1'b1);
    step();
    bus.d_rd_req = 0; bus.d_wr_req = 0;
    #1;
    chk("hazard refill m_rd_addr", bus.m_rd_addr, 32'h8000_1000);
    chk("second wb m_wr_req", bus.m_wr_req, 1'b1);
    chk("second wb m_wr_addr", bus.m_wr_addr, 32'h8000_3000);
    chk("second wb m_wr_data", bus.m_wr_data, pattern(32'h2222_5555));

    // ---------------- reset forces ready low, reset mid-burst ----------------
    idle_inputs();
    reset = 1;
    bus.i_rd_req = 1; bus.d_rd_req = 1; bus.d_wr_req = 1;
    step();
    #1;
    chk("in reset i_rd_rdy", bus.i_rd_rdy, 1'b0);
    chk("in reset d_rd_rdy", bus.d_rd_rdy, 1'b0);
    chk("in reset d_wr_rdy", bus.d_wr_rdy, 1'b0);
    step();
    reset = 0;
    idle_inputs();
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_4000;
    step();
    bus.d_rd_req = 0; bus.m_rd_rdy = 1;
    step();
    bus.m_rd_rdy = 0;
    for (int b = 0; b < 16; b++) begin
      bus.m_ret_valid = 1; bus.m_ret_data = 32'(b + 100); bus.m_ret_last = (b == 15);
      reset = (b == 5);
      #1;
      if (b < 5) chk($sformatf("mid beat%0d d_ret_valid", b), bus.d_ret_valid, 1'b1);
      if (b > 5) begin
        chk($sformatf("post-reset beat%0d d_ret_valid", b), bus.d_ret_valid, 1'b0);
        chk($sformatf("post-reset beat%0d i_ret_valid", b), bus.i_ret_valid, 1'b0);
        chk($sformatf("post-reset beat%0d m_rd_req", b), bus.m_rd_req, 1'b0);
        chk($sformatf("post-reset beat%0d m_wr_req", b), bus.m_wr_req, 1'b0);
      end
      step();
    end
    reset = 0;
    idle_inputs();

    // ---------------- memory stall on refill request ----------------
    do_reset();
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h1234_5678;
    step();
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_9000;
    prev_addr = 32'h1234_5640;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stall%0d m_rd_req", c), bus.m_rd_req, 1'b1);
      chk($sformatf("stall%0d m_rd_addr", c), bus.m_rd_addr, prev_addr);
      chk($sformatf("stall%0d rdy", c), {bus.i_rd_rdy, bus.d_rd_rdy}, 2'b00);
      step();
    end
    bus.m_rd_rdy = 1;
    #1;
    chk("stall release m_rd_req", bus.m_rd_req, 1'b1);
    step();
    #1;
    chk("stall accepted m_rd_req", bus.m_rd_req, 1'b0);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    mdl_full = 0; mdl_pending = 0; mdl_stream = 0; mdl_last = 0; mdl_owner = 0;
    mdl_addr = '0; mdl_wb_addr = '0; mdl_wb_data = '0; mem_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      bit hz_i, hz_d, el_i, el_d;
      int win;
      logic [8:0] exp_ctl, act_ctl;
      bus.i_rd_req = 1'($urandom_range(0, 1)); bus.i_rd_addr = rand_addr();
      bus.d_rd_req = 1'($urandom_range(0, 1)); bus.d_rd_addr = rand_addr();
      bus.d_wr_req = ($urandom_range(0, 3) == 0); bus.d_wr_addr = rand_addr();
      for (int w = 0; w < 16; w++) bus.d_wr_data[w*32 +: 32] = $urandom;
      bus.m_rd_rdy = ($urandom_range(0, 2) != 0);
      bus.m_wr_rdy = ($urandom_range(0, 3) == 0);
      bus.m_ret_data = $urandom;
      if (mdl_stream) begin
        bus.m_ret_valid = ($urandom_range(0, 3) != 0);
        bus.m_ret_last  = (mem_cnt == 15);
      end else begin
        bus.m_ret_valid = ($urandom_range(0, 7) == 0);
        bus.m_ret_last  = 1'($urandom_range(0, 1));
      end
      #1;
      hz_i = mdl_full && (bus.i_rd_addr[31:6] == mdl_wb_addr[31:6]);
      hz_d = mdl_full && (bus.d_rd_addr[31:6] == mdl_wb_addr[31:6]);
      el_i = bus.i_rd_req && !hz_i;
      el_d = bus.d_rd_req && !hz_d;
      win = -1;
      if (!mdl_pending && !mdl_stream) begin
        if (el_i && el_d) win = (FIXED || mdl_last == 0) ? 1 : 0;
        else if (el_d) win = 1;
        else if (el_i) win = 0;
      end
      exp_ctl = {win == 0, win == 1, mdl_pending,
                 mdl_stream && mdl_owner == 0 && bus.m_ret_valid,
                 mdl_stream && mdl_owner == 0 && bus.m_ret_valid && bus.m_ret_last,
                 mdl_stream && mdl_owner == 1 && bus.m_ret_valid,
                 mdl_stream && mdl_owner == 1 && bus.m_ret_valid && bus.m_ret_last,
                 !mdl_full, mdl_full};
      act_ctl = {bus.i_rd_rdy, bus.d_rd_rdy, bus.m_rd_req, bus.i_ret_valid, bus.i_ret_last,
                 bus.d_ret_valid, bus.d_ret_last, bus.d_wr_rdy, bus.m_wr_req};
      chk($sformatf("rand%0d ctl", c), act_ctl, exp_ctl);
      chk($sformatf("rand%0d ret_data", c), {bus.i_ret_data, bus.d_ret_data},
          {bus.m_ret_data, bus.m_ret_data});
      if (mdl_pending) chk($sformatf("rand%0d m_rd_addr", c), bus.m_rd_addr, mdl_addr);
      if (mdl_full) begin
        chk($sformatf("rand%0d m_wr_addr", c), bus.m_wr_addr, mdl_wb_addr);
        chk($sformatf("rand%0d m_wr_data", c), bus.m_wr_data, mdl_wb_data);
      end
      // advance the model by one cycle
      if (win >= 0) begin
        mdl_pending = 1; mdl_owner = win; mdl_last = win;
        mdl_addr = (win == 1 ? bus.d_rd_addr : bus.i_rd_addr) & ~32'd63;
      end else if (mdl_pending && bus.m_rd_rdy) begin
        mdl_pending = 0; mdl_stream = 1; mem_cnt = 0;
      end else if (mdl_stream && bus.m_ret_valid) begin
        if (bus.m_ret_last) begin mdl_stream = 0; mem_cnt = 0; end
        else mem_cnt++;
      end
      if (!mdl_full && bus.d_wr_req) begin
        mdl_full = 1; mdl_wb_addr = bus.d_wr_addr; mdl_wb_data = bus.d_wr_data;
      end else if (mdl_full && bus.m_wr_rdy) begin
        mdl_full = 0;
      end
      step();
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one memory-side line-refill/writeback port between the instruction cache (read-only) and the data cache (read plus dirty-line writeback).
- Arbitrates refill requests and routes WORDS_PER_LINE return beats to the owning cache.
- Holds one dirty line in a single-entry write buffer.
- Blocks any refill that targets the line still sitting in that buffer.

Parameters:
- BYTES_PER_LINE, 64, cache line size in bytes (power of two, ≥8)
- WORDS_PER_LINE, BYTES_PER_LINE/4, return beats per refill
- LINE_WIDTH, WORDS_PER_LINE*32, width of a writeback line
- OFFSET_WIDTH, $clog2(BYTES_PER_LINE), address bits below the line address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active high
- i_rd_req  in  1  icache refill request
- i_rd_addr  in  32  icache refill line address
- i_rd_rdy  out  1  icache request accepted this cycle
- i_ret_valid  out  1  refill beat for icache
- i_ret_last  out  1  final icache beat
- i_ret_data  out  32  refill beat data
- d_rd_req  in  1  dcache refill request
- d_rd_addr  in  32  dcache refill line address
- d_rd_rdy  out  1  dcache request accepted this cycle
- d_ret_valid  out  1  refill beat for dcache
- d_ret_last  out  1  final dcache beat
- d_ret_data  out  32  refill beat data
- d_wr_req  in  1  dcache writeback request
- d_wr_addr  in  32  writeback line address
- d_wr_data  in  LINE_WIDTH  writeback line
- d_wr_rdy  out  1  write buffer empty, writeback accepted
- m_rd_req  out  1  memory refill request
- m_rd_addr  out  32  memory refill address
- m_rd_rdy  in  1  memory accepts refill
- m_ret_valid  in  1  memory return beat
- m_ret_last  in  1  memory final beat
- m_ret_data  in  32  memory beat data
- m_wr_req  out  1  memory writeback request
- m_wr_addr  out  32  memory writeback address
- m_wr_data  out  LINE_WIDTH  memory writeback line
- m_wr_rdy  in  1  memory accepts writeback

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset; all state is cleared at the clk edge while it is asserted.
- Reset values:
  - read FSM in R_IDLE, owner none, last_grant=I
  - write buffer empty
  - m_rd_req=0, m_wr_req=0
  - i_rd_rdy=0, d_rd_rdy=0, d_wr_rdy=0 (forced low while reset is high)
  - i_ret_valid=0, d_ret_valid=0
- Line match: hazard = buffer full AND addr[31:OFFSET_WIDTH] == buffered addr[31:OFFSET_WIDTH].
- A requester is eligible when its req=1 and hazard=0.
- Read FSM states: R_IDLE, R_REQ, R_BUSY.
- R_IDLE:
  - Winner = eligible requester; if both are eligible, the one not equal to last_grant (round-robin).
  - Winner's rd_rdy=1 combinationally in the same cycle. At the edge, latch addr with the low OFFSET_WIDTH bits cleared, latch owner, update last_grant, go to R_REQ.
  - No eligible requester: stay in R_IDLE, both rd_rdy=0.
- R_REQ:
  - m_rd_req=1; m_rd_addr is the latched address, stable until accepted.
  - On m_rd_req&&m_rd_rdy go to R_BUSY.
- R_BUSY:
  - m_ret_valid routes to owner_ret_valid; the other ret_valid stays 0.
  - ret_data broadcasts m_ret_data to both caches. ret_last passes through to the owner only.
  - Beat counter (width $clog2(WORDS_PER_LINE)) increments on each beat and wraps to 0 on the last beat.
  - On m_ret_valid&&m_ret_last go to R_IDLE. The next grant is possible the following cycle, giving 1 idle cycle between refills.
- Beats arriving in R_IDLE/R_REQ, including after reset mid-burst, are dropped: no ret_valid is issued.
- Write buffer: d_wr_rdy = empty.
  - d_wr_req&&d_wr_rdy latches addr/data and sets full.
  - m_wr_req = full; m_wr_addr and m_wr_data come from the buffer.
  - m_wr_req&&m_wr_rdy clears full.
  - No accept occurs in the same cycle as a drain; the earliest refill the cycle after the drain.
- The write and read paths are independent: a writeback may drain while a refill is in R_BUSY.
- A refill to a non-matching line proceeds while the buffer is full.
- A blocked requester stays pending (rd_rdy=0) until the buffer drains; the other requester may be granted meanwhile.

Optional Feature:
- Macro CACHE_ARB_FIXED_PRIO_EN.
- Defined: when both requesters are eligible, the dcache always wins; last_grant is ignored.
- Undefined: round-robin as specified above.
- Hazard and write-buffer behaviour are identical in both builds.

Test Plan:
- Single icache refill: i_rd_req, addr 0x1fc0_0044 -> m_rd_addr=0x1fc0_0040 one cycle after grant; 16 beats 0..15 -> i_ret_valid×16, i_ret_last on the 16th beat, d_ret_valid=0 throughout.
- Both requesting continuously, 3 refills, round-robin build -> grant order D,I,D (last_grant reset=I); fixed-priority build -> D,D,D.
- Write then read hazard: d_wr at 0x8000_1000, m_wr_rdy held 0, d_rd_req 0x8000_1020 -> d_rd_rdy=0 until m_wr_rdy=1; grant one cycle after drain. Non-matching i_rd 0x8000_2000 -> granted while blocked.
- Second writeback while full -> d_wr_rdy=0; accepted the cycle after m_wr_req&&m_wr_rdy, with m_wr_data equal to the second line exactly.
- Reset asserted at beat 5 of a dcache refill -> next cycle all outputs at reset values; beats 6..15 still arriving -> d_ret_valid=0, i_ret_valid=0.
- Memory stalls m_rd_rdy=0 for 4 cycles -> m_rd_req and m_rd_addr held stable, no rd_rdy to any cache.
